// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Brief    : Shared AXI burst/response codes, slave FSM states and ID width.
// Revision : 1.0
// ============================================================================
package axi_pkg;

    localparam int c_ID_WIDTH = 4;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } axi_slv_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr_gen
// Brief    : Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Revision : 1.0
// ============================================================================
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LANE_BITS  = 3
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  size_err,
    output logic                  wrap_err
);

    localparam logic [2:0] c_MAX_SIZE = 3'(LANE_BITS);

    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_wrap_len;
    logic [ADDR_WIDTH-1:0] w_bound;
    logic [ADDR_WIDTH-1:0] w_incr;

    always_comb begin
        w_bytes    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
        w_wrap_len = ADDR_WIDTH'({1'b0, len} + 9'd1) << size;
        w_bound    = cur_addr & ~(w_wrap_len - {{(ADDR_WIDTH-1){1'b0}}, 1'b1});
        w_incr     = cur_addr + w_bytes;
        next_addr  = cur_addr;
        case (burst)
            c_BURST_INCR: next_addr = w_incr;
            // Wrap boundary is an aligned window of wrap_len bytes
            c_BURST_WRAP: next_addr = (w_incr == w_bound + w_wrap_len) ? w_bound : w_incr;
            default:      next_addr = cur_addr;
        endcase
        size_err = (size > c_MAX_SIZE);
        wrap_err = (burst == c_BURST_WRAP) &&
                   !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    end

endmodule
`default_nettype wire

// File: rtl/axi_slave_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_slave_write_ctrl
// Brief    : AXI write-channel slave; one burst at a time into a word memory.
// Revision : 1.0
// ============================================================================
module axi_slave_write_ctrl
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         AClk,
    input  logic                         ARst,
    input  logic [c_ID_WIDTH-1:0]        AWID,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic [7:0]                   AWLEN,
    input  logic [2:0]                   AWSIZE,
    input  logic [1:0]                   AWBURST,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [c_ID_WIDTH-1:0]        WID,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic [STRB_WIDTH-1:0]        WSTRB,
    input  logic                         WLAST,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [c_ID_WIDTH-1:0]        BID,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [STRB_WIDTH-1:0]        mem_wstrb,
    output logic                         wr_done
);

    localparam int c_LANE_BITS = $clog2(STRB_WIDTH);
    localparam int c_MEM_AW    = $clog2(MEM_DEPTH);

    axi_slv_state_e          r_state;
    logic [c_ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic [8:0]              r_beat_cnt;
    logic                    r_err;

    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic [ADDR_WIDTH-1:0]   w_word_idx;
    logic                    w_size_err;
    logic                    w_wrap_err;
    logic                    w_beat;
    logic                    w_last_beat;
    logic                    w_drop_all;
    logic                    w_drop_beat;
    logic                    w_beat_err;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANE_BITS  (c_LANE_BITS)
    ) u_addr_gen (
        .cur_addr  (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (w_next_addr),
        .size_err  (w_size_err),
        .wrap_err  (w_wrap_err)
    );

    assign w_word_idx  = r_addr >> c_LANE_BITS;
    assign w_beat      = WVALID && WREADY;
    assign w_last_beat = (r_beat_cnt == 9'd1);
    assign w_drop_all  = (r_burst == 2'b11) || w_size_err || w_wrap_err;
    assign w_drop_beat = w_drop_all || (w_word_idx >= ADDR_WIDTH'(MEM_DEPTH));
    // WLAST/WID mismatches flag the response but the beat is still written
    assign w_beat_err  = w_drop_beat || (WLAST != w_last_beat) || (WID != r_id);

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            r_state    <= ST_IDLE;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            AWREADY    <= 1'b0;
            WREADY     <= 1'b0;
            BID        <= '0;
            BRESP      <= '0;
            BVALID     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            wr_done    <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            wr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (AWREADY && AWVALID) begin
                        r_id       <= AWID;
                        r_addr     <= AWADDR;
                        r_len      <= AWLEN;
                        r_size     <= AWSIZE;
                        r_burst    <= AWBURST;
                        r_beat_cnt <= {1'b0, AWLEN} + 9'd1;
                        r_err      <= 1'b0;
                        AWREADY    <= 1'b0;
                        WREADY     <= 1'b1;
                        r_state    <= ST_DATA;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
                        mem_we     <= !w_drop_beat;
                        mem_addr   <= w_word_idx[c_MEM_AW-1:0];
                        mem_wdata  <= WDATA;
                        mem_wstrb  <= WSTRB;
                        r_addr     <= w_next_addr;
                        r_beat_cnt <= r_beat_cnt - 9'd1;
                        r_err      <= r_err || w_beat_err;
                        if (w_last_beat) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BID     <= r_id;
                            BRESP   <= (r_err || w_beat_err) ? c_RESP_SLVERR : c_RESP_OKAY;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        wr_done <= 1'b1;
                        AWREADY <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_slave_write_ctrl
// Brief    : Directed table, corner sequences and randomized bursts vs model.
// Revision : 1.0
// ============================================================================
module tb_axi_slave_write_ctrl;

    localparam int DEPTH = 256;

    logic        AClk, ARst;
    logic [3:0]  AWID, WID, BID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST, BRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [63:0] WDATA, mem_wdata;
    logic [7:0]  WSTRB, mem_wstrb, mem_addr;
    logic        mem_we, wr_done;

    axi_slave_write_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .STRB_WIDTH (8),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .AClk(AClk), .ARst(ARst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .wr_done(wr_done)
    );

    initial AClk = 1'b0;
    always #5 AClk = ~AClk;

    typedef struct packed {
        logic [7:0]  a;
        logic [63:0] d;
        logic [7:0]  s;
    } wr_t;

    typedef struct packed {
        logic [3:0]      id;
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        int              last_err;
        logic            wid_bad;
        logic [63:0]     data0;
        int              gaps;
        int              bdly;
        logic [1:0]      resp;
        int              n;
        logic [3:0][7:0] w;
        int              lat;
    } vec_t;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  done_cnt = 0;
    wr_t cap_q[$];
    wr_t sent_q[$];
    wr_t exp_q[$];

    always @(posedge AClk) cyc <= cyc + 1;

    always @(negedge AClk) begin
        if (mem_we) cap_q.push_back({mem_addr, mem_wdata, mem_wstrb});
        if (wr_done) done_cnt++;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input int last_err,
                                input logic wid_bad, input logic [63:0] data0, input int gaps,
                                input int bdly, input logic [1:0] resp, input int n,
                                input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                                input logic [7:0] w3, input int lat);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.last_err = last_err; v.wid_bad = wid_bad; v.data0 = data0; v.gaps = gaps;
        v.bdly = bdly; v.resp = resp; v.n = n; v.w = {w3, w2, w1, w0}; v.lat = lat;
        return v;
    endfunction

    // Expected writes and response from burst arithmetic on absolute beat index
    task automatic model(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int last_err, input bit wid_bad,
                         output logic [1:0] resp);
        longint bytes, wl, start, bound, a, word;
        bit drop_all, err;
        bytes    = longint'(1) << size;
        wl       = (longint'(len) + 1) * bytes;
        start    = longint'(addr);
        bound    = start - (start % wl);
        drop_all = (burst == 2'd3) || (size > 3'd3) ||
                   ((burst == 2'd2) && !(len == 1 || len == 3 || len == 7 || len == 15));
        err      = drop_all || (last_err >= 0) || wid_bad;
        exp_q.delete();
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                2'd0:    a = start;
                2'd1:    a = start + i * bytes;
                default: a = bound + ((start - bound) + i * bytes) % wl;
            endcase
            word = a >> 3;
            if (word >= DEPTH) err = 1'b1;
            else if (!drop_all) exp_q.push_back({word[7:0], sent_q[i].d, sent_q[i].s});
        end
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int last_err,
                             input bit wid_bad, input logic [63:0] data0, input bit rand_strb,
                             input int gap_max, input int bdly,
                             output logic [1:0] resp, output logic [3:0] bid, output int lat,
                             output bit stable);
        int t, hs;
        resp = 2'b00; bid = 4'h0; lat = -1; stable = 1'b1;
        cap_q.delete();
        sent_q.delete();
        @(negedge AClk);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < 50) begin @(negedge AClk); t++; end
        if (!AWREADY) begin chk("aw_timeout", 96'(AWREADY), 96'd1); AWVALID = 1'b0; return; end
        hs = cyc;
        @(negedge AClk);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin WVALID = 1'b0; @(negedge AClk); end
            WVALID = 1'b1;
            WID    = wid_bad ? (id ^ 4'h1) : id;
            WDATA  = (data0 != 64'd0) ? data0 + 64'(i) : {$urandom, $urandom};
            WSTRB  = rand_strb ? 8'($urandom) : 8'hFF;
            WLAST  = (i == int'(len)) ^ (i == last_err);
            t = 0;
            while (!WREADY && t < 50) begin @(negedge AClk); t++; end
            if (!WREADY) begin chk("w_timeout", 96'(WREADY), 96'd1); WVALID = 1'b0; return; end
            sent_q.push_back({8'h00, WDATA, WSTRB});
            @(negedge AClk);
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        t = 0;
        while (!BVALID && t < 50) begin @(negedge AClk); t++; end
        if (!BVALID) begin chk("b_timeout", 96'(BVALID), 96'd1); return; end
        lat  = cyc - hs;
        resp = BRESP;
        bid  = BID;
        repeat (bdly) begin
            @(negedge AClk);
            if (!(BVALID && BID == bid && BRESP == resp && !WREADY)) stable = 1'b0;
        end
        BREADY = 1'b1;
        @(negedge AClk);
        BREADY = 1'b0;
        chk("wr_done_pulse", {wr_done, BVALID}, 96'b10);
        @(negedge AClk);
        chk("awready_after_b", {AWREADY, wr_done}, 96'b10);
    endtask

    vec_t        vecs[12];
    logic [1:0]  g_resp, m_resp;
    logic [3:0]  g_bid;
    int          g_lat, d0, nn;
    bit          g_stable, idle_ok;
    logic [3:0]  r_id;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    int          r_lerr;
    bit          r_wbad;

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ARst = 1'b0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
        WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;

        //        id    addr      len   sz    bst   lerr wbad data0         gap bd rsp n  w0     w1     w2     w3     lat
        vecs[0]  = mk(4'h5, 32'h10,  8'd0, 3'd3, 2'd1, -1, 0, 64'hA5A5,     0, 0, 2'd0, 1, 8'd2,  8'd0,  8'd0,  8'd0,  2);
        vecs[1]  = mk(4'h3, 32'h0,   8'd3, 3'd3, 2'd1, -1, 0, 64'h1000,     2, 3, 2'd0, 4, 8'd0,  8'd1,  8'd2,  8'd3, -1);
        vecs[2]  = mk(4'hC, 32'h18,  8'd3, 3'd3, 2'd2, -1, 0, 64'h2000,     0, 0, 2'd0, 4, 8'd3,  8'd0,  8'd1,  8'd2, -1);
        vecs[3]  = mk(4'h1, 32'h0,   8'd1, 3'd3, 2'd3, -1, 0, 64'h3000,     0, 0, 2'd2, 0, 8'd0,  8'd0,  8'd0,  8'd0, -1);
        vecs[4]  = mk(4'h2, 32'h40,  8'd1, 3'd3, 2'd1,  0, 0, 64'h4000,     0, 1, 2'd2, 2, 8'd8,  8'd9,  8'd0,  8'd0, -1);
        vecs[5]  = mk(4'h6, 32'h20,  8'd2, 3'd3, 2'd0, -1, 0, 64'h5000,     1, 0, 2'd0, 3, 8'd4,  8'd4,  8'd4,  8'd0, -1);
        vecs[6]  = mk(4'h7, 32'h8,   8'd0, 3'd3, 2'd1, -1, 1, 64'h6000,     0, 0, 2'd2, 1, 8'd1,  8'd0,  8'd0,  8'd0, -1);
        vecs[7]  = mk(4'h8, 32'h0,   8'd0, 3'd4, 2'd1, -1, 0, 64'h7000,     0, 0, 2'd2, 0, 8'd0,  8'd0,  8'd0,  8'd0, -1);
        vecs[8]  = mk(4'h9, 32'h0,   8'd2, 3'd3, 2'd2, -1, 0, 64'h8000,     0, 0, 2'd2, 0, 8'd0,  8'd0,  8'd0,  8'd0, -1);
        vecs[9]  = mk(4'hA, 32'h7F8, 8'd1, 3'd3, 2'd1, -1, 0, 64'h9000,     0, 0, 2'd2, 1, 8'd255, 8'd0, 8'd0,  8'd0, -1);
        vecs[10] = mk(4'hB, 32'h4,   8'd3, 3'd2, 2'd1, -1, 0, 64'hA000,     1, 0, 2'd0, 4, 8'd0,  8'd1,  8'd1,  8'd2, -1);
        vecs[11] = mk(4'hD, 32'h0,   8'd1, 3'd3, 2'd1,  1, 0, 64'hB000,     0, 2, 2'd2, 2, 8'd0,  8'd1,  8'd0,  8'd0, -1);

        // Reset state and release timing
        repeat (3) @(negedge AClk);
        chk("reset_outputs", {AWREADY, WREADY, BVALID, BID, BRESP, mem_we, mem_addr,
                              mem_wdata, mem_wstrb, wr_done}, 96'd0);
        ARst = 1'b1;
        #1 chk("awready_before_edge", 96'(AWREADY), 96'd0);
        @(negedge AClk);
        chk("awready_after_release", 96'(AWREADY), 96'd1);

        // W traffic while idle must not be taken
        idle_ok = 1'b1;
        WVALID = 1'b1; WLAST = 1'b1; WDATA = 64'hDEAD;
        repeat (3) begin @(negedge AClk); if (WREADY || mem_we) idle_ok = 1'b0; end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("idle_w_ignored", {idle_ok, 31'd0, cap_q.size()}, {1'b1, 63'd0});

        for (int v = 0; v < 12; v++) begin
            d0 = done_cnt;
            run_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                      vecs[v].last_err, vecs[v].wid_bad, vecs[v].data0, 1'b0,
                      vecs[v].gaps, vecs[v].bdly, g_resp, g_bid, g_lat, g_stable);
            chk($sformatf("v%0d_bresp", v), 96'(g_resp), 96'(vecs[v].resp));
            chk($sformatf("v%0d_bid", v), 96'(g_bid), 96'(vecs[v].id));
            chk($sformatf("v%0d_b_stable", v), 96'(g_stable), 96'd1);
            chk($sformatf("v%0d_done_count", v), 96'(done_cnt - d0), 96'd1);
            chk($sformatf("v%0d_nwrites", v), 96'(cap_q.size()), 96'(vecs[v].n));
            if (vecs[v].lat >= 0) chk($sformatf("v%0d_latency", v), 96'(g_lat), 96'(vecs[v].lat));
            nn = (cap_q.size() < vecs[v].n) ? cap_q.size() : vecs[v].n;
            for (int k = 0; k < nn; k++) begin
                chk($sformatf("v%0d_w%0d_addr", v, k), 96'(cap_q[k].a), 96'(vecs[v].w[k]));
                chk($sformatf("v%0d_w%0d_data", v, k), {cap_q[k].d, cap_q[k].s},
                    {sent_q[k].d, sent_q[k].s});
            end
        end

        // Reset asserted while beat 2 of an 8-beat burst is presented
        @(negedge AClk);
        AWID = 4'h9; AWADDR = 32'h0; AWLEN = 8'd7; AWSIZE = 3'd3; AWBURST = 2'd1; AWVALID = 1'b1;
        nn = 0;
        while (!AWREADY && nn < 50) begin @(negedge AClk); nn++; end
        @(negedge AClk);
        AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            WVALID = 1'b1; WID = 4'h9; WDATA = 64'(i); WSTRB = 8'hFF; WLAST = 1'b0;
            nn = 0;
            while (!WREADY && nn < 50) begin @(negedge AClk); nn++; end
            @(negedge AClk);
        end
        WVALID = 1'b1; WDATA = 64'h2;
        #2 ARst = 1'b0;
        #1 chk("async_reset_outputs", {AWREADY, WREADY, BVALID, BID, BRESP, mem_we, mem_addr,
                                       mem_wdata, mem_wstrb, wr_done}, 96'd0);
        WVALID = 1'b0;
        @(negedge AClk);
        ARst = 1'b1;
        #1 chk("rst2_awready_before_edge", 96'(AWREADY), 96'd0);
        @(negedge AClk);
        chk("rst2_awready_after_release", {AWREADY, BVALID}, 96'b10);
        d0 = done_cnt;
        run_burst(4'h4, 32'h30, 8'd0, 3'd3, 2'd1, -1, 1'b0, 64'h77, 1'b0, 0, 0,
                  g_resp, g_bid, g_lat, g_stable);
        chk("post_reset_bresp", {g_bid, g_resp}, {4'h4, 2'b00});
        chk("post_reset_write", 96'(cap_q.size() == 1 ? {cap_q[0].a, cap_q[0].d} : 72'd0),
            {8'd6, 64'h77});
        chk("post_reset_done_count", 96'(done_cnt - d0), 96'd1);

        // Randomized bursts against the reference model
        for (int r = 0; r < 40; r++) begin
            r_id    = 4'($urandom);
            r_burst = ($urandom_range(9, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
            r_size  = ($urandom_range(7, 0) == 0) ? 3'd4 : 3'($urandom_range(3, 0));
            case ($urandom_range(5, 0))
                0: r_len = 8'd0;
                1: r_len = 8'd1;
                2: r_len = 8'd3;
                3: r_len = 8'd7;
                4: r_len = 8'd15;
                default: r_len = 8'($urandom_range(15, 0));
            endcase
            r_addr = 32'($urandom_range(32'h900, 0)) & ~((32'd1 << r_size) - 32'd1);
            r_lerr = ($urandom_range(5, 0) == 0) ? int'($urandom_range(r_len, 0)) : -1;
            r_wbad = ($urandom_range(7, 0) == 0);
            d0 = done_cnt;
            run_burst(r_id, r_addr, r_len, r_size, r_burst, r_lerr, r_wbad, 64'd0, 1'b1,
                      2, $urandom_range(2, 0), g_resp, g_bid, g_lat, g_stable);
            model(r_addr, r_len, r_size, r_burst, r_lerr, r_wbad, m_resp);
            chk($sformatf("r%0d_bresp", r), 96'(g_resp), 96'(m_resp));
            chk($sformatf("r%0d_bid", r), 96'(g_bid), 96'(r_id));
            chk($sformatf("r%0d_b_stable_done", r), {g_stable, 31'(done_cnt - d0)}, {1'b1, 31'd1});
            chk($sformatf("r%0d_nwrites", r), 96'(cap_q.size()), 96'(exp_q.size()));
            nn = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
            for (int k = 0; k < nn; k++)
                chk($sformatf("r%0d_w%0d", r, k), 96'(cap_q[k]), 96'(exp_q[k]));
        end

        repeat (2) @(negedge AClk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
